// File: rtl/silence_detect.sv
// Stereo silence detector with sample-count hysteresis.
// Flags SILENT after a run of quiet samples, clears after a run of loud ones.
module silence_detect #(
  parameter logic [31:0] THRESH        = 32'd256,
  parameter int          QUIET_SAMPLES = 4800,
  parameter int          LOUD_SAMPLES  = 48,
  parameter int          CNT_W         = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        sample_valid,
  input  logic [31:0] in_L,
  input  logic [31:0] in_R,
  output logic        silent,
  output logic        silence_start,
  output logic        silence_end
);

  typedef enum logic [1:0] {
    SOUND,
    QUIET_PEND,
    SILENT,
    LOUD_PEND
  } state_t;

  localparam logic [CNT_W-1:0] Q_LAST  = CNT_W'(QUIET_SAMPLES - 1);
  localparam logic [CNT_W-1:0] L_LAST  = CNT_W'(LOUD_SAMPLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             silent_q, silent_d;
  logic             start_q, start_d;
  logic             end_q, end_d;
  logic             quiet;
  logic [CNT_W-1:0] cnt_inc;

  // Most negative input has no positive twin; clamp it to the max.
  function automatic logic [31:0] mag(input logic [31:0] x);
    if (!x[31])
      return x;
    else if (x == 32'h8000_0000)
      return 32'h7FFF_FFFF;
    else
      return (~x) + 32'd1;
  endfunction

  assign quiet   = (mag(in_L) <= THRESH) && (mag(in_R) <= THRESH);
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    start_d = 1'b0;
    end_d   = 1'b0;
    if (!enable) begin
      state_d = SOUND;
      cnt_d   = '0;
      end_d   = (state_q == SILENT) || (state_q == LOUD_PEND);
    end else if (sample_valid) begin
      unique case (state_q)
        SOUND: begin
          if (quiet) begin
            if (QUIET_SAMPLES == 1) begin
              state_d = SILENT;
              cnt_d   = '0;
              start_d = 1'b1;
            end else begin
              state_d = QUIET_PEND;
              cnt_d   = CNT_ONE;
            end
          end
        end
        QUIET_PEND: begin
          if (!quiet) begin
            state_d = SOUND;
            cnt_d   = '0;
          end else if (cnt_q == Q_LAST) begin
            state_d = SILENT;
            cnt_d   = '0;
            start_d = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        SILENT: begin
          if (!quiet) begin
            if (LOUD_SAMPLES == 1) begin
              state_d = SOUND;
              cnt_d   = '0;
              end_d   = 1'b1;
            end else begin
              state_d = LOUD_PEND;
              cnt_d   = CNT_ONE;
            end
          end
        end
        LOUD_PEND: begin
          if (quiet) begin
            state_d = SILENT;
            cnt_d   = '0;
          end else if (cnt_q == L_LAST) begin
            state_d = SOUND;
            cnt_d   = '0;
            end_d   = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          state_d = SOUND;
          cnt_d   = '0;
        end
      endcase
    end
    silent_d = (state_d == SILENT) || (state_d == LOUD_PEND);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= SOUND;
      cnt_q    <= '0;
      silent_q <= 1'b0;
      start_q  <= 1'b0;
      end_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      silent_q <= silent_d;
      start_q  <= start_d;
      end_q    <= end_d;
    end
  end

  assign silent        = silent_q;
  assign silence_start = start_q;
  assign silence_end   = end_q;

endmodule

// File: tb/tb_silence_detect.sv
// Randomized scoreboard bench for silence_detect.
// Three configurations share one stimulus stream.
module tb_silence_detect;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        sample_valid;
  logic [31:0] in_L, in_R;
  logic [2:0]  sil, st, en;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  localparam int    QN[3] = '{4, 1, 1};
  localparam int    LN[3] = '{3, 1, 1};
  localparam longint TH[3] = '{256, 64'h7FFF_FFFF, 256};

  silence_detect #(
    .THRESH(32'd256), .QUIET_SAMPLES(4),
    .LOUD_SAMPLES(3), .CNT_W(16)
  ) u_a (
    .clk(clk), .reset(reset), .enable(enable),
    .sample_valid(sample_valid), .in_L(in_L), .in_R(in_R),
    .silent(sil[0]), .silence_start(st[0]), .silence_end(en[0])
  );

  silence_detect #(
    .THRESH(32'h7FFF_FFFF), .QUIET_SAMPLES(1),
    .LOUD_SAMPLES(1), .CNT_W(4)
  ) u_b (
    .clk(clk), .reset(reset), .enable(enable),
    .sample_valid(sample_valid), .in_L(in_L), .in_R(in_R),
    .silent(sil[1]), .silence_start(st[1]), .silence_end(en[1])
  );

  silence_detect #(
    .THRESH(32'd256), .QUIET_SAMPLES(1),
    .LOUD_SAMPLES(1), .CNT_W(4)
  ) u_c (
    .clk(clk), .reset(reset), .enable(enable),
    .sample_valid(sample_valid), .in_L(in_L), .in_R(in_R),
    .silent(sil[2]), .silence_start(st[2]), .silence_end(en[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: a silent flag plus lengths of the current quiet/loud runs.
  bit          m_sil[3];
  int          qrun[3];
  int          lrun[3];
  logic [8:0]  expq[$];

  function automatic bit is_quiet(int k, logic [31:0] l, logic [31:0] r);
    longint a, b;
    a = longint'($signed(l));
    b = longint'($signed(r));
    if (a < 0) a = -a;
    if (b < 0) b = -b;
    if (a > 64'h7FFF_FFFF) a = 64'h7FFF_FFFF;
    if (b > 64'h7FFF_FFFF) b = 64'h7FFF_FFFF;
    return (a <= TH[k]) && (b <= TH[k]);
  endfunction

  task automatic model(input bit rs, input bit e, input bit v,
                       input logic [31:0] l, input logic [31:0] r);
    logic [2:0] s, p, q;
    bit quiet;
    s = '0; p = '0; q = '0;
    for (int k = 0; k < 3; k++) begin
      if (rs) begin
        m_sil[k] = 0; qrun[k] = 0; lrun[k] = 0;
      end else if (!e) begin
        q[k] = m_sil[k];
        m_sil[k] = 0; qrun[k] = 0; lrun[k] = 0;
      end else if (v) begin
        quiet = is_quiet(k, l, r);
        if (!m_sil[k]) begin
          qrun[k] = quiet ? qrun[k] + 1 : 0;
          if (qrun[k] == QN[k]) begin
            m_sil[k] = 1; qrun[k] = 0; p[k] = 1;
          end
        end else begin
          lrun[k] = quiet ? 0 : lrun[k] + 1;
          if (lrun[k] == LN[k]) begin
            m_sil[k] = 0; lrun[k] = 0; q[k] = 1;
          end
        end
      end
      s[k] = m_sil[k];
    end
    expq.push_back({s, p, q});
  endtask

  task automatic step(input bit rs, input bit e, input bit v,
                      input logic [31:0] l, input logic [31:0] r);
    @(negedge clk);
    reset        = rs;
    enable       = e;
    sample_valid = v;
    in_L         = l;
    in_R         = r;
    model(rs, e, v, l, r);
    if (rs) begin
      #1;
      checks++;
      if ({sil, st, en} !== 9'd0) begin
        fails++;
        $display("FAIL async_reset cyc %0d got %b want %b",
                 cyc, {sil, st, en}, 9'd0);
      end
    end
  endtask

  task automatic smp(input logic [31:0] l, input logic [31:0] r);
    step(0, 1, 1, l, r);
  endtask

  always @(posedge clk) begin
    logic [8:0] x;
    cyc++;
    #1;
    if (expq.size() > 0) begin
      x = expq.pop_front();
      checks++;
      if ({sil, st, en} !== x) begin
        fails++;
        $display("FAIL outs cyc %0d got %b want %b", cyc, {sil, st, en}, x);
      end
    end
  end

  function automatic logic [31:0] gen(bit loud);
    int sel;
    if (!loud) return 32'($signed($urandom_range(512)) - 256);
    sel = $urandom_range(5);
    case (sel)
      0: return 32'd257;
      1: return -32'sd257;
      2: return 32'h8000_0000;
      3: return 32'd100000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bit loud_mode;
    reset = 1; enable = 1; sample_valid = 0; in_L = 0; in_R = 0;
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);

    // Four quiet samples enter SILENT on A.
    repeat (4) smp(32'd100, 32'd100);
    smp(32'd0, 32'd0);
    // Interrupted loud run, then a full one.
    repeat (2) smp(32'd1000, 32'd0);
    smp(32'd0, 32'd0);
    repeat (3) smp(32'd1000, 32'd0);
    // Quiet run broken at count 3 by a loud right channel.
    repeat (3) smp(32'd5, 32'd5);
    smp(32'd0, -32'sd300);
    repeat (3) smp(32'd5, 32'd5);
    smp(32'd5, 32'd5);
    // Min-int: loud for A and C, quiet for B.
    smp(32'h8000_0000, 32'd0);
    smp(32'd256, -32'sd256);
    smp(32'd257, 32'd0);
    // Loud data ignored without sample_valid.
    repeat (4) smp(32'd0, 32'd0);
    repeat (100) step(0, 1, 0, 32'd5000, 32'd5000);
    smp(32'd1, 32'd1);
    // Disable while silent, then reset mid quiet run.
    step(0, 0, 1, 32'd0, 32'd0);
    step(0, 0, 1, 32'd0, 32'd0);
    repeat (2) smp(32'd3, 32'd3);
    step(1, 1, 1, 32'd3, 32'd3);
    step(0, 1, 1, 32'd3, 32'd3);

    loud_mode = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) loud_mode = ~loud_mode;
      if ($urandom_range(499) == 0)
        step(1, 1, 0, 0, 0);
      else
        step(0, $urandom_range(59) != 0, $urandom_range(3) != 0,
             gen(loud_mode && $urandom_range(1) == 0),
             gen(loud_mode && $urandom_range(1) == 0));
    end

    step(0, 1, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (expq.size() != 0) begin
      fails++;
      $display("FAIL drain got %0d want 0", expq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
